// File: rtl/stage2_accum_mc.sv
// stage2_accum_mc: stage-2 integrator of the trapezoidal filter, multi-channel.
//
// Accumulates the signed delta stream from stage 1 for NCH time-interleaved
// channels, one ACC_W-bit accumulator per channel. Each accepted sample
// produces a one-cycle DOUT_VALID pulse on the following edge, carrying
// acc_new >>> SHIFT and the channel tag. Overflow is flagged per channel.
//
// Optional build macro: ACC_SAT_EN
//   defined   : accumulator and output saturate instead of wrapping
//   undefined : accumulator wraps; DATAOUT = acc_new[SHIFT+DOUT_W-1:SHIFT]
//
// Ports
//   SYS_CLK    in   1       clock, rising edge
//   RESET_N    in   1       asynchronous active-low reset
//   CLR        in   1       synchronous clear of all accumulators and OVF
//   DIN_VALID  in   1       DATAIN/DIN_CH valid this cycle
//   DIN_CH     in   CH_W    channel index of DATAIN
//   DATAIN     in   DIN_W   signed delta sample
//   DOUT_VALID out  1       one-cycle pulse per accepted sample
//   DOUT_CH    out  CH_W    channel of DATAOUT
//   DATAOUT    out  DOUT_W  signed scaled accumulator
//   OVF        out  NCH     sticky per-channel overflow flags
module stage2_accum_mc #(
   parameter int DIN_W  = 32,
   parameter int ACC_W  = 40,
   parameter int DOUT_W = 22,
   parameter int SHIFT  = 10,
   parameter int NCH    = 4,
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                     SYS_CLK,
   input  logic                     RESET_N,
   input  logic                     CLR,
   input  logic                     DIN_VALID,
   input  logic [CH_W-1:0]          DIN_CH,
   input  logic signed [DIN_W-1:0]  DATAIN,
   output logic                     DOUT_VALID,
   output logic [CH_W-1:0]          DOUT_CH,
   output logic signed [DOUT_W-1:0] DATAOUT,
   output logic [NCH-1:0]           OVF
);
   localparam int SE = ACC_W + 1 - DIN_W;

   logic signed [ACC_W-1:0]  acc [NCH];
   logic                     ch_ok;
   logic                     accept;
   logic [CH_W-1:0]          ch_idx;
   logic [ACC_W:0]           sum;
   logic                     ovf_now;
   logic signed [ACC_W-1:0]  acc_new;
   logic signed [DOUT_W-1:0] dout_next;

   // Channel indices beyond NCH only exist when NCH is not a power of two.
   generate
      if (NCH == (1 << CH_W)) begin : g_pow2
         assign ch_ok = 1'b1;
      end else begin : g_npow2
         assign ch_ok = (32'(DIN_CH) < NCH);
      end
   endgenerate

   assign accept = DIN_VALID && !CLR && ch_ok;
   assign ch_idx = ch_ok ? DIN_CH : '0;

   // One extra bit of headroom: overflow shows as the top two bits disagreeing.
   assign sum     = {acc[ch_idx][ACC_W-1], acc[ch_idx]} + {{SE{DATAIN[DIN_W-1]}}, DATAIN};
   assign ovf_now = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef ACC_SAT_EN
   logic signed [ACC_W-1:0]  shifted;
   logic [ACC_W-DOUT_W:0]    hi;
   logic                     fits;

   always_comb begin
      acc_new   = ovf_now ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                          : sum[ACC_W-1:0];
      shifted   = acc_new >>> SHIFT;
      hi        = shifted[ACC_W-1:DOUT_W-1];
      fits      = (&hi) | ~(|hi);
      dout_next = fits ? shifted[DOUT_W-1:0]
                       : (shifted[ACC_W-1] ? {1'b1, {(DOUT_W-1){1'b0}}} : {1'b0, {(DOUT_W-1){1'b1}}});
   end
`else
   // Arithmetic shift then truncate is just a bit slice of the accumulator.
   always_comb begin
      acc_new   = sum[ACC_W-1:0];
      dout_next = acc_new[SHIFT+DOUT_W-1:SHIFT];
   end
`endif

   always_ff @(posedge SYS_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NCH; i++) acc[i] <= '0;
         OVF        <= '0;
         DOUT_VALID <= 1'b0;
         DOUT_CH    <= '0;
         DATAOUT    <= '0;
      end else if (CLR) begin
         for (int i = 0; i < NCH; i++) acc[i] <= '0;
         OVF        <= '0;
         DOUT_VALID <= 1'b0;
      end else begin
         DOUT_VALID <= accept;
         if (accept) begin
            acc[ch_idx] <= acc_new;
            DOUT_CH     <= ch_idx;
            DATAOUT     <= dout_next;
            if (ovf_now) OVF[ch_idx] <= 1'b1;
         end
      end
   end
endmodule
